// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [PC_W-1:0]    PC_STEP          = 64'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

  // Commit record handed to decode; first member is the MSB field.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    next_pc;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } commit_info_t;

  localparam int unsigned COMMIT_W       = $bits(commit_info_t);
  localparam int unsigned CI_VALID_LSB   = 0;
  localparam int unsigned CI_PC_LSB      = 1;
  localparam int unsigned CI_NEXT_PC_LSB = 65;
  localparam int unsigned CI_INSTR_LSB   = 129;

  function automatic commit_info_t make_commit(input logic [PC_W-1:0]    pc,
                                               input logic [INSTR_W-1:0] instr);
    commit_info_t c;
    c.valid   = 1'b1;
    c.pc      = pc;
    c.next_pc = pc + PC_STEP;
    c.instr   = instr;
    return c;
  endfunction

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry pc+instr holding buffer for a response that arrives while decode is stalled.
module ifu_skid_buf
  import ifu_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               pop,
  input  logic               flush,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= in_pc;
      instr <= in_instr;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one-outstanding imem requests, stall skid, redirect kill.
// Optional IFU_FETCH_PERF_EN adds perf_fetched / perf_stall_cycles counters.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                fetch_stall,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_W-1:0]     imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INSTR_W-1:0]  imem_resp_data,
  output logic                fetch_o_valid,
  output logic [PC_W-1:0]     fetch_o_pc,
  output logic [INSTR_W-1:0]  fetch_o_instr,
  output logic [COMMIT_W-1:0] fetch_o_commit_info
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [63:0]         perf_fetched,
  output logic [63:0]         perf_stall_cycles
`endif
);

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic               kill_q, kill_d;
  commit_info_t       slot_q;
  logic               slot_load, slot_clear;
  logic [PC_W-1:0]    slot_pc;
  logic [INSTR_W-1:0] slot_instr;
  logic               skid_load, skid_pop, skid_flush, skid_valid;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               req_fire;

  // Only combinational output: request is withheld while decode is stalled.
  assign imem_req_valid = rst_n && (state_q == S_REQ) && !fetch_stall;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc_q;

  assign fetch_o_valid       = slot_q.valid;
  assign fetch_o_pc          = slot_q.pc;
  assign fetch_o_instr       = slot_q.instr;
  assign fetch_o_commit_info = slot_q;

  ifu_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .pop      (skid_pop),
    .flush    (skid_flush),
    .in_pc    (req_pc_q),
    .in_instr (imem_resp_data),
    .valid    (skid_valid),
    .pc       (skid_pc),
    .instr    (skid_instr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
      if (slot_load)       slot_q <= make_commit(slot_pc, slot_instr);
      else if (slot_clear) slot_q <= '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    slot_load  = 1'b0;
    slot_clear = !fetch_stall;
    slot_pc    = req_pc_q;
    slot_instr = imem_resp_data;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
    skid_flush = 1'b0;

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      slot_clear = 1'b1;
      skid_flush = 1'b1;
      // A request still in flight (or accepted this cycle) must be killed on return.
      if ((state_q == S_WAIT && !imem_resp_valid) || req_fire) begin
        state_d = S_WAIT;
        kill_d  = 1'b1;
      end else begin
        state_d = S_REQ;
        kill_d  = 1'b0;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state_d = S_REQ;
            if (kill_q) begin
              kill_d = 1'b0;
            end else begin
              pc_d = req_pc_q + PC_STEP;
              if (fetch_stall && slot_q.valid) begin
                skid_load = 1'b1;
                state_d   = S_HOLD;
              end else begin
                slot_load = 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          if (!fetch_stall) begin
            state_d = S_REQ;
            if (skid_valid) begin
              slot_load  = 1'b1;
              slot_pc    = skid_pc;
              slot_instr = skid_instr;
              skid_pop   = 1'b1;
            end
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

`ifdef IFU_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_fetched      <= perf_fetched + 64'(slot_load);
      perf_stall_cycles <= perf_stall_cycles + 64'(fetch_stall && slot_q.valid);
    end
  end
`endif

endmodule
